// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and the range-mask helper for the LFSR
// random source.
package lfsr_pkg;

  // Draw unit states: idle, stepping and checking candidates, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_e;

  // Maximal-length Galois tap masks for a right-shifting register.
  localparam logic [7:0]  TAPS_8  = 8'hB8;         // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] TAPS_16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
  localparam logic [23:0] TAPS_24 = 24'hE10000;    // x^24+x^23+x^22+x^17+1
  localparam logic [31:0] TAPS_32 = 32'h80200003;  // x^32+x^22+x^2+x+1

  // Smallest 2^k-1 that covers bound-1, so a masked candidate lands in
  // [0, 2*bound) and is accepted with probability above one half.
  // A bound of 0 stands for 2^width and yields all ones in the low width bits.
  function automatic logic [31:0] range_mask(input logic [31:0] bound,
                                             input int unsigned width);
    logic [31:0] m;
    logic [31:0] mask;
    m    = bound - 32'd1;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (bound == 32'd0) mask[i] = (i < width);
      else                mask[i] = ((m >> i) != 32'd0);
    end
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register: seed load has priority over stepping, and a
// zero seed is replaced by SEED so the all-zero lockup state is unreachable.
module lfsr_core #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Compute the stepped value and choose between hold, load and step.
  always_comb begin
    next_state = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
    state_d    = state_q;
    if (seed_load)  state_d = (seed_in == '0) ? SEED : seed_in;
    else if (step)  state_d = next_state;
  end

  // State register, reset to the seed.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random source with a request/valid draw unit that returns an unbiased
// value in [0, range_max) by rejection sampling, with a bounded fallback.
// Optional: define LFSR_REJECT_STATS_EN to add a saturating reject_count output.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      OUT_WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_16,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  input  logic [OUT_WIDTH-1:0] range_max,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] value,
  output logic [WIDTH-1:0]     random
`ifdef LFSR_REJECT_STATS_EN
  ,
  output logic [15:0]          reject_count
`endif
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  draw_state_e          state_q, state_d;
  logic [OUT_WIDTH-1:0] bound_q, bound_d;
  logic [OUT_WIDTH-1:0] mask_q, mask_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [OUT_WIDTH-1:0] value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic                 step;
  logic [WIDTH-1:0]     next_state;
  logic [OUT_WIDTH-1:0] cand;
  logic                 accept;
  logic                 reject;

  assign step = (enable || state_q == DRAW) && !seed_load;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .Clk        (Clk),
    .Reset      (Reset),
    .step       (step),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .state      (random),
    .next_state (next_state)
  );

  // Draw FSM next-state: latch the bound on accept, then test one candidate
  // per stepped cycle until accepted or the try budget forces a fallback.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    value_d = value_q;
    reject  = 1'b0;
    cand    = OUT_WIDTH'(next_state) & mask_q;
    accept  = (bound_q == '0) || (cand < bound_q);

    unique case (state_q)
      IDLE: begin
        if (req) begin
          bound_d = range_max;
          mask_d  = OUT_WIDTH'(range_mask(32'(range_max), OUT_WIDTH));
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // A seed load freezes the LFSR, so there is no fresh candidate.
        if (!seed_load) begin
          if (accept) begin
            value_d = cand;
            state_d = DONE;
          end else begin
            reject = 1'b1;
            if (tries_q == LAST_TRY) begin
              // Dropping the top mask bit guarantees a value below bound.
              value_d = cand & (mask_q >> 1);
              state_d = DONE;
            end else begin
              tries_d = TRY_W'(tries_q + 1'b1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // Draw FSM registers; outputs are registered so req never reaches valid
  // combinationally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bound_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bound_q <= bound_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign value = value_q;

`ifdef LFSR_REJECT_STATS_EN
  logic [15:0] reject_count_q, reject_count_d;

  // Saturating count of rejected candidates, cleared only by reset.
  always_comb begin
    reject_count_d = reject_count_q;
    if (reject && reject_count_q != 16'hFFFF) reject_count_d = reject_count_q + 16'd1;
  end

  // Reject counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) reject_count_q <= '0;
    else       reject_count_q <= reject_count_d;
  end

  assign reject_count = reject_count_q;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: stepping, seed load, draw latency, rejection,
// fallback, busy-ignore and asynchronous abort. Honours LFSR_REJECT_STATS_EN.
module tb_lfsr_rng;

  logic        Clk;
  logic        Reset;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed_in;

  logic        req, req1;
  logic [7:0]  range_max, range_max1;
  logic        busy, busy1;
  logic        valid, valid1;
  logic [7:0]  value, value1;
  logic [15:0] random, random1;
`ifdef LFSR_REJECT_STATS_EN
  logic [15:0] reject_count, reject_count1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  lfsr_rng dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .req          (req),
    .range_max    (range_max),
    .busy         (busy),
    .valid        (valid),
    .value        (value),
    .random       (random)
`ifdef LFSR_REJECT_STATS_EN
    ,
    .reject_count (reject_count)
`endif
  );

  lfsr_rng #(.MAX_TRIES(1)) dut1 (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .req          (req1),
    .range_max    (range_max1),
    .busy         (busy1),
    .valid        (valid1),
    .value        (value1),
    .random       (random1)
`ifdef LFSR_REJECT_STATS_EN
    ,
    .reject_count (reject_count1)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
    req = 1'b0; range_max = '0; req1 = 1'b0; range_max1 = '0;
    tick();
    check("rst_random", random, 32'hACE1);
    check("rst_busy",   busy,   0);
    check("rst_valid",  valid,  0);
    check("rst_value",  value,  0);
    Reset = 1'b0;

    // Free-run stepping.
    enable = 1'b1;
    tick(); check("step1", random, 32'hE270);
    tick(); check("step2", random, 32'h7138);
    enable = 1'b0;

    // range_max=0: full range, latency 2.
    do_reset();
    range_max = 8'h00; req = 1'b1;
    tick(); req = 1'b0;
    check("full_c1_valid", valid, 0);
    check("full_c1_busy",  busy,  1);
    tick();
    check("full_c2_valid", valid, 1);
    check("full_c2_value", value, 32'h70);
    tick();
    check("full_c3_valid", valid, 0);
    check("full_c3_busy",  busy,  0);

    // range_max=0x60: 0x70 rejected, 0x38 accepted in cycle 3.
    do_reset();
    range_max = 8'h60; req = 1'b1;
    tick(); req = 1'b0;
    tick(); check("rej_c2_valid", valid, 0);
    tick();
    check("rej_c3_valid", valid, 1);
    check("rej_c3_value", value, 32'h38);
`ifdef LFSR_REJECT_STATS_EN
    check("rej_count", reject_count, 1);
`endif

    // Reset mid-draw aborts without a clock edge.
    tick();
    req = 1'b1;
    tick(); req = 1'b0;
    check("abort_busy_before", busy, 1);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy",  busy,  0);
    check("abort_valid", valid, 0);
    check("abort_value", value, 0);
    tick();
    Reset = 1'b0;

    // range_max=1: always 0, latency 2; then seed loads.
    do_reset();
    range_max = 8'h01; req = 1'b1;
    tick(); req = 1'b0;
    tick();
    check("one_valid", valid, 1);
    check("one_value", value, 0);
    check("one_random", random, 32'hE270);
    seed_load = 1'b1; seed_in = 16'h0000;
    tick(); check("seed_zero", random, 32'hACE1);
    seed_in = 16'h1234;
    tick(); check("seed_1234", random, 32'h1234);
    enable = 1'b1; seed_in = 16'h00FF;
    tick(); check("seed_over_enable", random, 32'h00FF);
    seed_load = 1'b0;
    tick(); check("step_after_seed", random, 32'hB47F);
    enable = 1'b0;

    // Seed load during DRAW: no step, no check, draw continues.
    do_reset();
    range_max = 8'h60; req = 1'b1;
    tick(); req = 1'b0;
    seed_load = 1'b1; seed_in = 16'h0000;
    tick(); seed_load = 1'b0;
    check("sl_draw_random", random, 32'hACE1);
    check("sl_draw_valid",  valid,  0);
    check("sl_draw_busy",   busy,   1);
    tick(); check("sl_draw_c3_valid", valid, 0);
    tick();
    check("sl_draw_c4_valid", valid, 1);
    check("sl_draw_c4_value", value, 32'h38);

    // MAX_TRIES=1 fallback; req held while busy must be ignored.
    do_reset();
    range_max1 = 8'h60; req1 = 1'b1;
    pulses = 0;
    tick();
    check("fb_c1_busy", busy1, 1);
    if (valid1) pulses++;
    tick();
    check("fb_c2_valid", valid1, 1);
    check("fb_c2_value", value1, 32'h30);
`ifdef LFSR_REJECT_STATS_EN
    check("fb_rej_count", reject_count1, 1);
`endif
    if (valid1) pulses++;
    tick();
    req1 = 1'b0;
    if (valid1) pulses++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid1) pulses++;
    end
    check("fb_pulses", pulses, 1);
    check("fb_idle_busy", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Galois LFSR random source for game logic such as spawn positions, alien behaviour and timing jitter. It extends a free-running 8-bit LFSR with:
- configurable width and tap polynomial;
- seed load with lockup protection;
- a request/valid draw unit that returns an unbiased value in [0, range_max) using rejection sampling.

Sits beside the game FSMs; one instance per independent random stream.

Parameters:
WIDTH, 16, LFSR state width (8..32)
OUT_WIDTH, 8, width of drawn value and range bound (<= WIDTH)
TAPS, 16'hB400, Galois tap mask (maximal-length x^16+x^14+x^13+x^11+1)
SEED, 16'hACE1, reset/fallback seed; must be nonzero
MAX_TRIES, 8, rejection attempts before fallback

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
enable  in  1  free-run step of the LFSR when no draw is stepping it
seed_load  in  1  load seed_in into state this cycle
seed_in  in  WIDTH  new seed; 0 is replaced by SEED
req  in  1  draw request; accepted only when busy=0
range_max  in  OUT_WIDTH  exclusive upper bound, latched on accept; 0 means 2^OUT_WIDTH
busy  out  1  draw in progress (state != IDLE)
valid  out  1  one-cycle pulse; value is valid
value  out  OUT_WIDTH  drawn result, held until the next valid
random  out  WIDTH  raw LFSR state

Behaviour:
- Reset (async, active-high): random=SEED, FSM=IDLE, busy=0, valid=0, value=0, try counter=0.
- Step: lsb=state[0]; state<=state>>1; if lsb, state^=TAPS. Example: 0xACE1 -> 0xE270 -> 0x7138.
- Zero state is unreachable: seed_in==0 loads SEED.
- State update priority: seed_load > step. A step occurs if (enable || FSM==DRAW) && !seed_load.
- FSM IDLE: when req=1, latch bound=range_max, compute mask, clear tries, go to DRAW. req while busy is ignored, not queued.
- Mask: the smallest 2^k-1 >= bound-1. bound=0 gives all ones; bound=1 gives 0.
- FSM DRAW, each cycle a step occurs:
  - cand = next_state[OUT_WIDTH-1:0] & mask.
  - Accept when bound==0 or cand<bound: value<=cand, go to DONE.
  - Otherwise tries++.
  - When tries reaches MAX_TRIES-1 and the candidate is rejected, value <= cand & (mask>>1), which is always < bound; go to DONE.
- seed_load during DRAW: that cycle performs no step and no check; tries is unchanged and the draw continues.
- FSM DONE: valid=1 for exactly one cycle, then IDLE. busy=1 in DRAW and DONE.
- Latency: req high in cycle 0 gives valid in cycle 2 at the earliest. Each rejection adds one cycle; worst case is cycle MAX_TRIES+1.
- A new req is accepted in the cycle after DONE, so back-to-back draws are every 3 cycles minimum.
- Reset mid-draw aborts: IDLE, valid=0, value=0.
- value and random are registered; no combinational path from req to valid.

Optional Feature:
LFSR_REJECT_STATS_EN
- Defined: adds output reject_count[15:0], which counts rejected candidates.
  - Saturates at 0xFFFF.
  - Cleared by Reset only.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lfsr_pkg:
  - draw FSM state enum (IDLE, DRAW, DONE);
  - default maximal tap constants for widths 8/16/24/32;
  - mask function (bound -> smallest 2^k-1).
- Sub-module lfsr_core (WIDTH, TAPS, SEED): state register, step and seed-load priority, zero-seed substitution.
- lfsr_rng instantiates lfsr_core and owns the draw FSM.

Test Plan:
1. Reset, enable=1 for 2 cycles -> random 0xACE1, 0xE270, 0x7138.
2. req with range_max=0 right after reset -> valid 2 cycles later, value=0x70.
3. req with range_max=0x60 after reset -> candidate 0x70 rejected, 0x38 accepted; valid in cycle 3, value=0x38.
4. range_max=1 -> value=0 with latency 2. seed_load with seed_in=0 -> random=0xACE1.
5. MAX_TRIES=1, range_max=0x60 from reset -> fallback value 0x70&0x3F=0x30, valid in cycle 2. req while busy -> ignored, only one valid pulse.
6. Assert Reset during DRAW -> busy, valid and value drop immediately without a clock edge. With LFSR_REJECT_STATS_EN defined, scenario 3 gives reject_count=1.
